// File: rtl/inst_encoder.sv
// inst_encoder
//   Packs field-level instruction commands into 32-bit MIPS words (R-type,
//   lw, sw, beq, j) and writes them sequentially into instruction memory,
//   starting at BASE_ADDR after each start pulse.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               one-cycle pulse, begins a load (honoured in IDLE only)
//   in_valid/in_ready   command handshake; in_ready is high only in RUN
//   in_kind             0=R, 1=lw, 2=sw, 3=beq, 4=j, 5..7 illegal
//   in_rs/rt/rd/funct   register and function fields
//   in_imm, in_target   immediate (lw/sw/beq) and jump target (j)
//   in_last             command terminates the program
//   mem_we/addr/wdata   registered instruction-memory write port
//   busy, done          state is RUN / one-cycle end-of-load pulse
//   err_illegal         sticky, an illegal kind was consumed since start
//   count               words written since start
module inst_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] KIND_R   = 3'd0;
    localparam logic [2:0] KIND_LW  = 3'd1;
    localparam logic [2:0] KIND_SW  = 3'd2;
    localparam logic [2:0] KIND_BEQ = 3'd3;
    localparam logic [2:0] KIND_J   = 3'd4;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_SLOT = '1;

    state_t            state, nextState;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       encWord;
    logic              accept;
    logic              legal;
    logic              lastWrite;
    logic              finish;

    assign accept    = in_valid & in_ready;
    assign legal     = (in_kind <= KIND_J);
    // Writing the top slot ends the load: the address never wraps back
    // below BASE_ADDR within one load.
    assign lastWrite = accept & legal & (addr == LAST_SLOT);
    assign finish    = accept & (in_last | lastWrite);

    // Field packing; shamt is always zero, unused fields per kind dropped.
    always_comb begin
        encWord = 32'h0;
        case (in_kind)
            KIND_R:   encWord = {OP_R, in_rs, in_rt, in_rd, 5'b00000, in_funct};
            KIND_LW:  encWord = {OP_LW, in_rs, in_rt, in_imm};
            KIND_SW:  encWord = {OP_SW, in_rs, in_rt, in_imm};
            KIND_BEQ: encWord = {OP_BEQ, in_rs, in_rt, in_imm};
            KIND_J:   encWord = {OP_J, in_target};
            default:  encWord = 32'h0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = RUN;
            RUN:     if (finish) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State-decoded outputs; nothing here depends on in_valid.
    always_comb begin
        in_ready = (state == RUN);
        busy     = (state == RUN);
        done     = (state == DONE);
    end

    // Datapath: address/count tracking and the registered memory write.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr        <= BASE;
            count       <= '0;
            err_illegal <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 32'h0;
        end else begin
            mem_we <= 1'b0;
            if (state == IDLE && start) begin
                addr        <= BASE;
                count       <= '0;
                err_illegal <= 1'b0;
            end
            if (accept) begin
                if (legal) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr;
                    mem_wdata <= encWord;
                    addr      <= addr + ADDR_W'(1);
                    count     <= count + (ADDR_W+1)'(1);
                end else begin
                    err_illegal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, inValid = 1'b0;
    logic        sStart = 1'b0, sValid = 1'b0;
    logic [2:0]  kind = 3'd0;
    logic [4:0]  rs = 5'd0, rt = 5'd0, rd = 5'd0;
    logic [5:0]  funct = 6'd0;
    logic [15:0] imm = 16'd0;
    logic [25:0] target = 26'd0;
    logic        last = 1'b0;

    logic        inReady, memWe, busy, done, errIllegal;
    logic [7:0]  memAddr;
    logic [31:0] memWdata;
    logic [8:0]  count;

    logic        sInReady, sMemWe, sBusy, sDone, sErr;
    logic [1:0]  sMemAddr;
    logic [31:0] sMemWdata;
    logic [2:0]  sCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(inValid),
        .in_ready(inReady), .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd),
        .in_funct(funct), .in_imm(imm), .in_target(target), .in_last(last),
        .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata), .busy(busy),
        .done(done), .err_illegal(errIllegal), .count(count)
    );

    inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dutSmall (
        .clk(clk), .reset(reset), .start(sStart), .in_valid(sValid),
        .in_ready(sInReady), .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd),
        .in_funct(funct), .in_imm(imm), .in_target(target), .in_last(last),
        .mem_we(sMemWe), .mem_addr(sMemAddr), .mem_wdata(sMemWdata), .busy(sBusy),
        .done(sDone), .err_illegal(sErr), .count(sCount)
    );

    typedef struct {
        logic        newLoad;
        logic [2:0]  kind;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
        logic        expWe;
        logic [7:0]  expAddr;
        logic [31:0] expData;
        logic        expDone;
        logic [8:0]  expCount;
        logic        expErr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Idle one cycle so any DONE has returned to IDLE, then pulse start.
    task automatic loadStart();
        @(negedge clk);
        inValid = 1'b0; start = 1'b0;
        @(posedge clk);
        #1 chk("done_one_cycle", {31'd0, done}, 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_ready", {31'd0, inReady}, 32'd1);
        chk("start_count", {23'd0, count}, 32'd0);
        chk("start_err_clr", {31'd0, errIllegal}, 32'd0);
    endtask

    task automatic drive(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                         input logic [25:0] tg, input logic l);
        kind = k; rs = s; rt = t; rd = d; funct = f; imm = i; target = tg; last = l;
    endtask

    logic vPat[7];
    logic sPat[7];
    logic [7:0] expA;

    initial begin
        //            new  kind  rs     rt     rd     funct   imm        target    last  we    addr   data          done  count  err
        vecs[0] = '{1'b1, 3'd1, 5'd9,  5'd8,  5'd0,  6'h00, 16'h0004, 26'h0,     1'b0, 1'b1, 8'd0, 32'h8D280004, 1'b0, 9'd1, 1'b0};
        vecs[1] = '{1'b0, 3'd2, 5'd9,  5'd8,  5'd0,  6'h00, 16'h0008, 26'h0,     1'b1, 1'b1, 8'd1, 32'hAD280008, 1'b1, 9'd2, 1'b0};
        vecs[2] = '{1'b1, 3'd0, 5'd1,  5'd2,  5'd3,  6'h20, 16'hABCD, 26'h3FFFF, 1'b0, 1'b1, 8'd0, 32'h00221820, 1'b0, 9'd1, 1'b0};
        vecs[3] = '{1'b0, 3'd3, 5'd1,  5'd2,  5'd7,  6'h3F, 16'hFFFF, 26'h0,     1'b0, 1'b1, 8'd1, 32'h1022FFFF, 1'b0, 9'd2, 1'b0};
        vecs[4] = '{1'b0, 3'd4, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'h1234, 26'h10,    1'b1, 1'b1, 8'd2, 32'h08000010, 1'b1, 9'd3, 1'b0};
        vecs[5] = '{1'b1, 3'd1, 5'd1,  5'd2,  5'd0,  6'h00, 16'h0010, 26'h0,     1'b0, 1'b1, 8'd0, 32'h8C220010, 1'b0, 9'd1, 1'b0};
        vecs[6] = '{1'b0, 3'd6, 5'd5,  5'd6,  5'd7,  6'h01, 16'h5555, 26'h0,     1'b0, 1'b0, 8'd0, 32'h8C220010, 1'b0, 9'd1, 1'b1};
        vecs[7] = '{1'b0, 3'd2, 5'd3,  5'd4,  5'd0,  6'h00, 16'h0020, 26'h0,     1'b1, 1'b1, 8'd1, 32'hAC640020, 1'b1, 9'd2, 1'b1};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, inReady}, 32'd0);
        chk("rst_we", {31'd0, memWe}, 32'd0);
        chk("rst_addr", {24'd0, memAddr}, 32'd0);
        chk("rst_wdata", memWdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, errIllegal}, 32'd0);
        chk("rst_count", {23'd0, count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("idle_ready", {31'd0, inReady}, 32'd0);

        // Table-driven encode/write sequences
        for (int n = 0; n < 8; n++) begin
            if (vecs[n].newLoad) loadStart();
            @(negedge clk);
            drive(vecs[n].kind, vecs[n].rs, vecs[n].rt, vecs[n].rd, vecs[n].funct,
                  vecs[n].imm, vecs[n].target, vecs[n].last);
            inValid = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", n), {31'd0, memWe}, {31'd0, vecs[n].expWe});
            chk($sformatf("v%0d_addr", n), {24'd0, memAddr}, {24'd0, vecs[n].expAddr});
            chk($sformatf("v%0d_data", n), memWdata, vecs[n].expData);
            chk($sformatf("v%0d_done", n), {31'd0, done}, {31'd0, vecs[n].expDone});
            chk($sformatf("v%0d_count", n), {23'd0, count}, {23'd0, vecs[n].expCount});
            chk($sformatf("v%0d_err", n), {31'd0, errIllegal}, {31'd0, vecs[n].expErr});
            if (vecs[n].expDone)
                chk($sformatf("v%0d_done_ready", n), {31'd0, inReady}, 32'd0);
        end
        // err_illegal is held through DONE/IDLE and cleared by the next start
        @(negedge clk);
        inValid = 1'b0;
        #1 chk("err_sticky", {31'd0, errIllegal}, 32'd1);
        loadStart();
        // leave this load running; reset below clears it

        // Reset coincident with an accept: accept dropped
        @(negedge clk);
        drive(3'd1, 5'd9, 5'd8, 5'd0, 6'd0, 16'h4, 26'd0, 1'b0);
        inValid = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstacc_we", {31'd0, memWe}, 32'd0);
        chk("rstacc_busy", {31'd0, busy}, 32'd0);
        chk("rstacc_count", {23'd0, count}, 32'd0);
        @(negedge clk);
        reset = 1'b0; inValid = 1'b0;

        // Reset the cycle after an accept: strobe cleared, state cleared
        loadStart();
        @(negedge clk);
        inValid = 1'b1;
        @(posedge clk);
        #1 chk("rst2_we_before", {31'd0, memWe}, 32'd1);
        @(negedge clk);
        inValid = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_we", {31'd0, memWe}, 32'd0);
        chk("rst2_busy", {31'd0, busy}, 32'd0);
        chk("rst2_count", {23'd0, count}, 32'd0);
        chk("rst2_addr", {24'd0, memAddr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADDR_W=2: fills the four slots then stops without wrapping
        @(negedge clk);
        sStart = 1'b1;
        @(posedge clk);
        #1 sStart = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(3'd1, 5'(i), 5'(i + 1), 5'd0, 6'd0, 16'(i * 4), 26'd0, 1'b0);
            sValid = 1'b1;
            #1 chk($sformatf("s%0d_ready", i), {31'd0, sInReady}, {31'd0, i < 4});
            @(posedge clk);
            #1;
            chk($sformatf("s%0d_we", i), {31'd0, sMemWe}, {31'd0, i < 4});
            if (i < 4) begin
                chk($sformatf("s%0d_addr", i), {30'd0, sMemAddr}, i);
                chk($sformatf("s%0d_data", i), sMemWdata,
                    {6'b100011, 5'(i), 5'(i + 1), 16'(i * 4)});
            end
            chk($sformatf("s%0d_done", i), {31'd0, sDone}, {31'd0, i == 3});
        end
        @(negedge clk);
        sValid = 1'b0;
        chk("s_count", {29'd0, sCount}, 32'd4);
        chk("s_err", {31'd0, sErr}, 32'd0);

        // Gapped in_valid with start pulses mid-RUN
        vPat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        sPat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        loadStart();
        expA = 8'd0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(3'd0, 5'd1, 5'd2, 5'd3, 6'(i), 16'd0, 26'd0, i == 6);
            inValid = vPat[i];
            start = sPat[i];
            @(posedge clk);
            #1;
            chk($sformatf("g%0d_we", i), {31'd0, memWe}, {31'd0, vPat[i]});
            if (vPat[i]) begin
                chk($sformatf("g%0d_addr", i), {24'd0, memAddr}, {24'd0, expA});
                chk($sformatf("g%0d_data", i), memWdata, 32'h00221800 | 32'(i));
                expA = expA + 8'd1;
            end
            chk($sformatf("g%0d_count", i), {23'd0, count}, {24'd0, expA});
        end
        chk("g_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        inValid = 1'b0; start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
